// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_port_arbiter
// Description : Shares one DRAM port between an instruction-fetch requester
//               and a data (load/store) requester. Only one transaction is
//               outstanding at a time. The port is held for RD_LATENCY
//               cycles, then the owner gets a one-cycle done pulse. Data wins
//               by default. Fetch is forced to win after STARV_LIMIT data
//               grants have been made while it was waiting.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               if_req/if_addr    - fetch request (held until if_done)
//               if_done/if_rdata  - fetch completion pulse and data
//               d_req/d_addr/d_wdata/d_rd_ctrl/d_wr_ctrl
//                                 - data request (held until d_done)
//               d_done/d_rdata    - data completion pulse and load data
//               dram_addr/dram_din/dram_rd_ctrl/dram_wr_ctrl/dram_dout
//                                 - shared DRAM port
//               stall_pipe        - pipeline stall while a data access pends
// Revision    : 1.0 - initial release
// ============================================================================
module dram_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int RD_LATENCY  = 2,
  parameter int STARV_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_rd_ctrl,
  input  logic [2:0]        d_wr_ctrl,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_din,
  output logic [2:0]        dram_rd_ctrl,
  output logic [2:0]        dram_wr_ctrl,
  input  logic [DATA_W-1:0] dram_dout,
  output logic              stall_pipe
);

  localparam int CNT_W = ($clog2(RD_LATENCY + 1) < 1) ? 1 : $clog2(RD_LATENCY + 1);
  localparam int STV_W = ($clog2(STARV_LIMIT + 1) < 1) ? 1 : $clog2(STARV_LIMIT + 1);

  localparam logic [CNT_W-1:0] c_lat       = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(1);
  localparam logic [STV_W-1:0] c_starv_max = STV_W'(STARV_LIMIT);
  localparam logic [2:0]       c_fetch_rd  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STV_W-1:0]    starv_q, starv_d;
  logic [ADDR_W-1:0]   dram_addr_q, dram_addr_d;
  logic [DATA_W-1:0]   dram_din_q, dram_din_d;
  logic [2:0]          dram_rd_q, dram_rd_d;
  logic [2:0]          dram_wr_q, dram_wr_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_done_q, if_done_d;
  logic                d_done_q, d_done_d;

  logic                w_fetch_wins;
  logic [STV_W-1:0]    w_starv_inc;
  logic [DATA_W-1:0]   w_rd_data;

  // Fetch wins if it is alone, or if it has been starved long enough.
  assign w_fetch_wins = if_req & (~d_req | (starv_q == c_starv_max));
  assign w_starv_inc  = (starv_q == c_starv_max) ? starv_q : starv_q + 1'b1;
  // Only a real read returns data; stores and ctrl-less accesses yield 0.
  assign w_rd_data    = (dram_rd_q != 3'b000) ? dram_dout : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      starv_q     <= '0;
      dram_addr_q <= '0;
      dram_din_q  <= '0;
      dram_rd_q   <= '0;
      dram_wr_q   <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starv_q     <= starv_d;
      dram_addr_q <= dram_addr_d;
      dram_din_q  <= dram_din_d;
      dram_rd_q   <= dram_rd_d;
      dram_wr_q   <= dram_wr_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starv_d     = starv_q;
    dram_addr_d = dram_addr_q;
    dram_din_d  = dram_din_q;
    dram_rd_d   = dram_rd_q;
    dram_wr_d   = dram_wr_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_fetch_wins) begin
          owner_d     = OWN_IF;
          dram_addr_d = if_addr;
          dram_din_d  = '0;
          dram_rd_d   = c_fetch_rd;
          dram_wr_d   = 3'b000;
          cnt_d       = c_lat;
          starv_d     = '0;
          state_d     = S_WAIT;
        end else if (d_req) begin
          owner_d     = OWN_D;
          dram_addr_d = d_addr;
          dram_din_d  = d_wdata;
          dram_rd_d   = d_rd_ctrl;
          dram_wr_d   = d_wr_ctrl;
          cnt_d       = c_lat;
          // Only grants that bypass a waiting fetch count toward starvation.
          starv_d     = if_req ? w_starv_inc : '0;
          state_d     = S_WAIT;
        end else begin
          starv_d     = '0;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == c_cnt_last) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = w_rd_data;
            if_done_d  = 1'b1;
          end else if (owner_q == OWN_D) begin
            d_rdata_d  = w_rd_data;
            d_done_d   = 1'b1;
          end
          // Release the port so it reads all-zero during the response cycle.
          dram_addr_d = '0;
          dram_din_d  = '0;
          dram_rd_d   = 3'b000;
          dram_wr_d   = 3'b000;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if_rdata_d = '0;
        d_rdata_d  = '0;
        owner_d    = OWN_NONE;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign if_done      = if_done_q;
  assign if_rdata     = if_rdata_q;
  assign d_done       = d_done_q;
  assign d_rdata      = d_rdata_q;
  assign dram_addr    = dram_addr_q;
  assign dram_din     = dram_din_q;
  assign dram_rd_ctrl = dram_rd_q;
  assign dram_wr_ctrl = dram_wr_q;
  // Held low while reset is asserted even if a data request is present.
  assign stall_pipe   = d_req & ~d_done_q & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_port_arbiter
// Description : Self-checking bench for dram_port_arbiter. A behavioural
//               DRAM model answers reads; expected read data is queued per
//               requester when a request is driven and compared when the
//               matching done pulse appears. Directed sequences check cycle
//               timing, arbitration order, starvation, reset abort and a
//               RD_LATENCY=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_done;
  logic [63:0] if_rdata;
  logic        d_req;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [2:0]  d_rd_ctrl;
  logic [2:0]  d_wr_ctrl;
  logic        d_done;
  logic [63:0] d_rdata;
  logic [63:0] dram_addr;
  logic [63:0] dram_din;
  logic [2:0]  dram_rd_ctrl;
  logic [2:0]  dram_wr_ctrl;
  logic [63:0] dram_dout;
  logic        stall_pipe;

  // RD_LATENCY = 1 instance
  logic        r1_if_req;
  logic [63:0] r1_if_addr;
  logic        r1_if_done;
  logic [63:0] r1_if_rdata;
  logic        r1_d_done;
  logic [63:0] r1_d_rdata;
  logic [63:0] r1_dram_addr;
  logic [63:0] r1_dram_din;
  logic [2:0]  r1_dram_rd_ctrl;
  logic [2:0]  r1_dram_wr_ctrl;
  logic [63:0] r1_dram_dout;
  logic        r1_stall_pipe;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [63:0] if_q[$];
  logic [63:0] d_q[$];

  function automatic logic [63:0] dram_model(input logic [63:0] a);
    return a ^ 64'hDEAD_BEEF_8000_0001;
  endfunction

  assign dram_dout    = (dram_rd_ctrl != 3'b000) ? dram_model(dram_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
  assign r1_dram_dout = (r1_dram_rd_ctrl != 3'b000) ? dram_model(r1_dram_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  dram_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .RD_LATENCY(2), .STARV_LIMIT(4)
  ) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rd_ctrl(d_rd_ctrl), .d_wr_ctrl(d_wr_ctrl),
    .d_done(d_done), .d_rdata(d_rdata),
    .dram_addr(dram_addr), .dram_din(dram_din),
    .dram_rd_ctrl(dram_rd_ctrl), .dram_wr_ctrl(dram_wr_ctrl),
    .dram_dout(dram_dout), .stall_pipe(stall_pipe)
  );

  dram_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .RD_LATENCY(1), .STARV_LIMIT(4)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(r1_if_req), .if_addr(r1_if_addr), .if_done(r1_if_done), .if_rdata(r1_if_rdata),
    .d_req(1'b0), .d_addr(64'h0), .d_wdata(64'h0),
    .d_rd_ctrl(3'b000), .d_wr_ctrl(3'b000),
    .d_done(r1_d_done), .d_rdata(r1_d_rdata),
    .dram_addr(r1_dram_addr), .dram_din(r1_dram_din),
    .dram_rd_ctrl(r1_dram_rd_ctrl), .dram_wr_ctrl(r1_dram_wr_ctrl),
    .dram_dout(r1_dram_dout), .stall_pipe(r1_stall_pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the owner's next expected datum.
  always @(negedge clk) begin
    if (if_done && d_done) check("both_done", 64'd1, 64'd0);
    if (if_done) begin
      if (if_q.size() == 0) check("if_done_unexpected", 64'd1, 64'd0);
      else check("if_rdata", if_rdata, if_q.pop_front());
    end
    if (d_done) begin
      if (d_q.size() == 0) check("d_done_unexpected", 64'd1, 64'd0);
      else check("d_rdata", d_rdata, d_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output logic is_if, output int at_cyc, input int budget);
    logic seen;
    seen   = 1'b0;
    is_if  = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (if_done || d_done) begin
        seen   = 1'b1;
        is_if  = if_done;
        at_cyc = cyc;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   t;
    int   at;
    logic isif;
    logic [63:0] a;

    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_addr = '0;
    d_wdata = '0; d_rd_ctrl = '0; d_wr_ctrl = '0; r1_if_req = 1'b0; r1_if_addr = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_if_done", if_done, 0);
    check("rst_d_done", d_done, 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    check("rst_dram", {dram_rd_ctrl, dram_wr_ctrl}, 0);
    check("rst_dram_addr_din", dram_addr | dram_din, 0);
    check("rst_stall", stall_pipe, 0);
    step();
    reset = 1'b0;
    step();

    // 1: fetch-only read
    if_req = 1'b1; if_addr = 64'h8000_0000;
    if_q.push_back(64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    check("t1_rd_grant_cycle", dram_rd_ctrl, 3'b000);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check("t1_rd_ctrl", dram_rd_ctrl, 3'b111);
      check("t1_addr", dram_addr, 64'h8000_0000);
      check("t1_din_wr", {dram_din, 1'b0, dram_wr_ctrl}, 0);
      check("t1_if_done_early", if_done, 0);
    end
    @(negedge clk);
    check("t1_if_done", if_done, 1);
    check("t1_rd_ctrl_resp", dram_rd_ctrl, 3'b000);
    step();
    if_req = 1'b0;
    step();

    // 2: data store
    d_req = 1'b1; d_addr = 64'h8000_0010; d_wdata = 64'h55; d_wr_ctrl = 3'b011; d_rd_ctrl = 3'b000;
    d_q.push_back(64'h0);
    @(negedge clk);
    check("t2_stall_t", stall_pipe, 1);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check("t2_wr_ctrl", dram_wr_ctrl, 3'b011);
      check("t2_din", dram_din, 64'h55);
      check("t2_addr", dram_addr, 64'h8000_0010);
      check("t2_rd_ctrl", dram_rd_ctrl, 3'b000);
      check("t2_stall", stall_pipe, 1);
    end
    @(negedge clk);
    check("t2_d_done", d_done, 1);
    check("t2_stall_done", stall_pipe, 0);
    check("t2_wr_ctrl_resp", dram_wr_ctrl, 3'b000);
    step();
    d_req = 1'b0; d_wr_ctrl = 3'b000;
    step();

    // Data request with no ctrl codes: granted, completes with zero data
    d_req = 1'b1; d_addr = 64'h1234_5678; d_wdata = 64'hFFFF;
    d_q.push_back(64'h0);
    t = cyc;
    @(negedge clk);
    @(negedge clk);
    check("nc_dram_ctrl", {dram_rd_ctrl, dram_wr_ctrl}, 0);
    wait_done(isif, at, 5);
    check("nc_is_data", isif, 0);
    check("nc_latency", at - t, 3);
    step();
    d_req = 1'b0;
    step();

    // 3: simultaneous requests; data first, fetch 4 cycles later
    a = 64'h8000_0100;
    if_req = 1'b1; if_addr = a;
    d_req = 1'b1; d_addr = 64'h8000_0200; d_rd_ctrl = 3'b011; d_wr_ctrl = 3'b000;
    if_q.push_back(dram_model(a));
    d_q.push_back(dram_model(64'h8000_0200));
    t = cyc;
    wait_done(isif, at, 6);
    check("t3_first_is_data", isif, 0);
    check("t3_d_latency", at - t, 3);
    t = at;
    step();
    d_req = 1'b0;
    wait_done(isif, at, 8);
    check("t3_second_is_if", isif, 1);
    check("t3_if_after_d", at - t, 4);
    step();
    if_req = 1'b0;
    step();

    // 4: starvation; 4 data grants then fetch, then data resumes
    if_req = 1'b1; if_addr = 64'h8000_1000;
    if_q.push_back(dram_model(64'h8000_1000));
    d_req = 1'b1; d_addr = 64'h9000_0000; d_rd_ctrl = 3'b111;
    d_q.push_back(dram_model(64'h9000_0000));
    for (int k = 0; k < 6; k++) begin
      wait_done(isif, at, 10);
      check($sformatf("t4_order_%0d", k), isif, (k == 4) ? 1 : 0);
      step();
      if (k < 4) begin
        d_addr = 64'h9000_0000 + 64'(k + 1) * 64'h40;
        d_q.push_back(dram_model(d_addr));
      end
      if (k == 4) if_req = 1'b0;
      if (k == 5) d_req = 1'b0;
    end
    step();

    // 5: reset during WAIT of a load aborts without a done pulse
    d_req = 1'b1; d_addr = 64'hA000_0000; d_rd_ctrl = 3'b011;
    @(negedge clk);
    @(negedge clk);
    check("t5_in_wait", dram_rd_ctrl, 3'b011);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("t5_stall_in_reset", stall_pipe, 0);
    step();
    reset = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("t5_dram_zero", {dram_rd_ctrl, dram_wr_ctrl}, 0);
    check("t5_addr_din_zero", dram_addr | dram_din, 0);
    check("t5_dones_zero", {if_done, d_done}, 0);
    check("t5_rdata_zero", if_rdata | d_rdata, 0);
    check("t5_stall_zero", stall_pipe, 0);
    repeat (4) @(negedge clk);
    step();
    if_req = 1'b1; if_addr = 64'hB000_0008;
    if_q.push_back(dram_model(64'hB000_0008));
    t = cyc;
    wait_done(isif, at, 6);
    check("t5_fresh_is_if", isif, 1);
    check("t5_fresh_latency", at - t, 3);
    step();
    if_req = 1'b0;
    step();

    // 6: RD_LATENCY = 1 instance
    r1_if_req = 1'b1; r1_if_addr = 64'h8000_0000;
    @(negedge clk);
    check("t6_rd_grant_cycle", r1_dram_rd_ctrl, 3'b000);
    @(negedge clk);
    check("t6_rd_ctrl", r1_dram_rd_ctrl, 3'b111);
    check("t6_done_early", r1_if_done, 0);
    @(negedge clk);
    check("t6_if_done", r1_if_done, 1);
    check("t6_if_rdata", r1_if_rdata, 64'hDEAD_BEEF_0000_0001);
    check("t6_rd_ctrl_resp", r1_dram_rd_ctrl, 3'b000);
    step();
    r1_if_req = 1'b0;
    repeat (3) step();

    check("sb_if_empty", 64'(if_q.size()), 0);
    check("sb_d_empty", 64'(d_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Sequences a single shared DRAM port between two requesters:
  - instruction fetch (IF side);
  - data access (MEMP side, load/store with rd/wr ctrl codes).
- Allows one outstanding transaction, issued for a fixed latency, with a one-cycle completion pulse to the owner.
- Uses priority arbitration with starvation protection for fetch.
- Generates the pipeline stall used while a data access is pending.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- RD_LATENCY, 2, cycles the DRAM port is held per transaction (≥1)
- STARV_LIMIT, 4, consecutive data grants made while if_req is pending before fetch is forced to win

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held until if_done
- if_addr  input  ADDR_W  fetch address
- if_done  output  1  one-cycle completion pulse
- if_rdata  output  DATA_W  fetch data; valid while if_done=1
- d_req  input  1  data request; held until d_done
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_rd_ctrl  input  3  load ctrl code (0 = none)
- d_wr_ctrl  input  3  store ctrl code (0 = none)
- d_done  output  1  one-cycle completion pulse
- d_rdata  output  DATA_W  load data; valid while d_done=1 (0 for stores)
- dram_addr  output  ADDR_W  DRAM address
- dram_din  output  DATA_W  DRAM write data
- dram_rd_ctrl  output  3  DRAM read ctrl
- dram_wr_ctrl  output  3  DRAM write ctrl
- dram_dout  input  DATA_W  DRAM read data
- stall_pipe  output  1  stall request to the pipeline

Behaviour:

Clocking and reset:
- clk and reset only; reset is synchronous and active-high.

Reset:
- State goes to IDLE and owner to none.
- All outputs are 0, including both done pulses, both rdata outputs and all dram_* outputs.
- starv_cnt and the latency counter are cleared.
- Reset mid-transaction aborts it: no done pulse is issued, and the dram ctrl outputs are 0 on the cycle after reset is sampled.

FSM (IDLE, WAIT, RESP):

IDLE:
- Arbitrate among the requests present this cycle.
- On a grant at the edge ending cycle t:
  - latch owner;
  - drive dram_addr/din/rd_ctrl/wr_ctrl from the winner;
  - fetch wins: rd_ctrl = 3'b111 (64-bit load), wr_ctrl = 0, din = 0;
  - load cnt = RD_LATENCY;
  - go to WAIT.
- With no request, stay in IDLE.

WAIT:
- dram_* outputs stay stable from cycle t+1 through t+RD_LATENCY.
- cnt decrements each cycle.
- On the cycle where cnt==1:
  - capture dram_dout into the owner's rdata register (0 for stores);
  - go to RESP.

RESP (cycle t+RD_LATENCY+1):
- Pulse the owner's done for exactly one cycle.
- All dram_* outputs are 0.
- Go to IDLE.
- The next grant is decided in the following cycle.
- The requester is expected to drop or change its request in the cycle after done.

Timing:
- Request-to-done latency is RD_LATENCY+1 cycles from the grant cycle: 3 cycles for the default, with done at t+3.
- Back-to-back transactions are spaced RD_LATENCY+2 cycles apart.

Arbitration:
- Data wins over fetch by default.
- starv_cnt counts data grants made while if_req=1; it saturates at STARV_LIMIT.
- It clears on any fetch grant, and in any IDLE cycle with if_req=0.
- If starv_cnt==STARV_LIMIT and if_req=1, fetch wins.

Request validity:
- A d_req with both ctrl codes 0 is still granted.
- It completes normally with d_rdata=0, and the DRAM ctrl outputs stay 0.

stall_pipe:
- Combinational: stall_pipe = d_req & ~d_done.
- It is 0 during reset.

Done outputs:
- if_done and d_done are never 1 in the same cycle.

Test Plan:
1. Fetch-only read: reset high for 2 cycles, then released; if_req=1 with if_addr=0x8000_0000; dram_dout=0xDEAD_BEEF_0000_0001 while dram_rd_ctrl≠0. Required: grant at cycle t; dram_rd_ctrl=3'b111 at t+1..t+2; if_done=1 only at t+3 with if_rdata=0xDEAD_BEEF_0000_0001; dram_rd_ctrl=0 at t+3.
2. Data store: d_req=1 with d_addr=0x8000_0010, d_wdata=0x55, d_wr_ctrl=3'b011. Required: dram_wr_ctrl=3'b011 and dram_din=0x55 for 2 cycles; d_done at t+3 with d_rdata=0; stall_pipe=1 from t to t+2 and 0 at t+3.
3. Simultaneous requests: if_req and d_req both asserted in the same IDLE cycle. Required: data is served first; fetch is granted in the IDLE cycle after d_done; if_done arrives 4 cycles after d_done.
4. Starvation: if_req held and d_req reasserted immediately after every d_done. Required: exactly 4 data transactions complete, then a fetch completes, then data resumes.
5. Reset mid-operation: assert reset during WAIT of a load. Required: the next cycle has all outputs 0 and state IDLE; no done pulse appears; a fresh request afterwards completes with normal latency.
6. Parameter RD_LATENCY=1: fetch read. Required: dram_rd_ctrl high for 1 cycle (t+1); if_done at t+2.
